// File: rtl/vpn_cipher_sched.sv
// Round-robin scheduler sharing one fixed-latency XOR cipher engine between NUM_CH channels.
// Optional per-channel grant statistics are enabled with `define VPN_SCHED_STATS_EN.

module vpn_key_lane #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] wkey,
    output logic [DATA_W-1:0] key
`ifdef VPN_SCHED_STATS_EN
    ,
    input  logic              hs,
    output logic [15:0]       cnt
`endif
);
    always_ff @(posedge clk) begin
        if (rst)     key <= '1;
        else if (we) key <= wkey;
    end

`ifdef VPN_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                         cnt <= '0;
        else if (hs && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
    end
`endif
endmodule

module vpn_cipher_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 16,
    parameter int ENG_LAT    = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [DATA_W-1:0]          cfg_key,
    output logic                       eng_valid,
    output logic [DATA_W-1:0]          eng_data,
    output logic [DATA_W-1:0]          eng_key,
    input  logic [DATA_W-1:0]          eng_rdata,
    output logic                       resp_valid,
    output logic [$clog2(NUM_CH)-1:0]  resp_ch,
    output logic [DATA_W-1:0]          resp_data,
    input  logic                       resp_ready
`ifdef VPN_SCHED_STATS_EN
    ,
    input  logic [$clog2(NUM_CH)-1:0]  stat_ch,
    output logic [15:0]                stat_cnt
`endif
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(RESP_DEPTH);
    localparam int UW = AW + 1;

    typedef struct packed {
        logic [CW-1:0]     ch;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic [NUM_CH-1:0][DATA_W-1:0] req_words;
    logic [DATA_W-1:0]             keys [NUM_CH];
    logic [CW-1:0]                 rr_ptr, win, idx;
    logic                          found, grant, push, pop;
    logic [UW-1:0]                 used, fcount;
    logic [ENG_LAT:0]              vld_pipe;
    logic [ENG_LAT:0][CW-1:0]      ch_pipe;
    resp_t                         fifo [RESP_DEPTH];
    logic [AW-1:0]                 wr_ptr, rd_ptr;

    assign req_words = req_data;

    // First requester at or after rr_ptr wins; credits gate the grant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CW'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant = found && (used < UW'(RESP_DEPTH));
    end

    assign req_ready = grant ? (NUM_CH'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (rst)        rr_ptr <= '0;
        else if (grant) rr_ptr <= (win == CW'(NUM_CH - 1)) ? '0 : win + 1'b1;
    end

`ifdef VPN_SCHED_STATS_EN
    logic [15:0] grant_cnt [NUM_CH];
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        vpn_key_lane #(.DATA_W(DATA_W)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .we   (cfg_we && (cfg_ch == CW'(g))),
            .wkey (cfg_key),
            .key  (keys[g])
`ifdef VPN_SCHED_STATS_EN
            ,
            .hs   (grant && (win == CW'(g))),
            .cnt  (grant_cnt[g])
`endif
        );
    end

    // vld_pipe[0] is the issue stage itself; vld_pipe[ENG_LAT] lines up with eng_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            ch_pipe  <= '0;
            eng_data <= '0;
            eng_key  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[ENG_LAT-1:0], grant};
            ch_pipe  <= {ch_pipe[ENG_LAT-1:0], win};
            if (grant) begin
                eng_data <= req_words[win];
                eng_key  <= keys[win];
            end
        end
    end

    assign eng_valid = vld_pipe[0];

    assign push       = vld_pipe[ENG_LAT];
    assign resp_valid = (fcount != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_ch    = resp_valid ? fifo[rd_ptr].ch   : '0;
    assign resp_data  = resp_valid ? fifo[rd_ptr].data : '0;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= resp_t'{ch: ch_pipe[ENG_LAT], data: eng_rdata};
    end

    // Credits cover in-flight plus buffered words, so a push always finds room.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
            used   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fcount <= fcount + UW'(push) - UW'(pop);
            used   <= used + UW'(grant) - UW'(pop);
        end
    end

`ifdef VPN_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                                     stat_cnt <= '0;
        else if ({1'b0, stat_ch} < (CW+1)'(NUM_CH))  stat_cnt <= grant_cnt[stat_ch];
        else                                         stat_cnt <= '0;
    end
`endif
endmodule

// File: tb/tb_vpn_cipher_sched.sv
// Self-checking bench for vpn_cipher_sched: directed scenarios plus randomized traffic
// against a queue-based reference model of grants, keys and response ordering.
module tb_vpn_cipher_sched;
    localparam int NUM_CH = 4, DATA_W = 16, ENG_LAT = 1, RESP_DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        req_valid = '0;
    logic [NUM_CH*DATA_W-1:0] req_data = '0;
    logic [NUM_CH-1:0]        req_ready;
    logic                     cfg_we = 1'b0;
    logic [1:0]               cfg_ch = '0;
    logic [15:0]              cfg_key = '0;
    logic                     eng_valid;
    logic [15:0]              eng_data, eng_key, eng_rdata;
    logic                     resp_valid;
    logic [1:0]               resp_ch;
    logic [15:0]              resp_data;
    logic                     resp_ready = 1'b0;
`ifdef VPN_SCHED_STATS_EN
    logic [1:0]               stat_ch = '0;
    logic [15:0]              stat_cnt;
`endif

    int total = 0, bad = 0;

    vpn_cipher_sched #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ENG_LAT(ENG_LAT), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_key(cfg_key),
        .eng_valid(eng_valid), .eng_data(eng_data), .eng_key(eng_key), .eng_rdata(eng_rdata),
        .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_data(resp_data), .resp_ready(resp_ready)
`ifdef VPN_SCHED_STATS_EN
        , .stat_ch(stat_ch), .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Engine stand-in: data ^ key delayed by ENG_LAT cycles.
    logic [15:0] epipe [ENG_LAT];
    always @(posedge clk) begin
        epipe[0] <= eng_data ^ eng_key;
        for (int i = 1; i < ENG_LAT; i++) epipe[i] <= epipe[i-1];
    end
    assign eng_rdata = epipe[ENG_LAT-1];

    // Reference model: every accepted word becomes visible at cycle T+2+ENG_LAT, in order.
    typedef struct {
        int          ch;
        logic [15:0] d;
        int          rdy;
    } ent_t;
    ent_t        mq[$];
    int          m_rr = 0;
    logic [15:0] m_key [NUM_CH];
    int          cyc = 0;

    function automatic int m_pick();
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (m_rr + i) % NUM_CH;
            if (req_valid[c]) return (mq.size() < RESP_DEPTH) ? c : -1;
        end
        return -1;
    endfunction

    function automatic logic [NUM_CH-1:0] m_ready();
        int p;
        p = m_pick();
        if (p < 0) return '0;
        return NUM_CH'(1) << p;
    endfunction

    function automatic bit m_rv();
        return (mq.size() > 0) && (mq[0].rdy <= cyc);
    endfunction

    task automatic tick();
        int   p;
        bit   pop;
        ent_t e;
        p   = m_pick();
        pop = m_rv() && resp_ready;
        if (rst) begin
            mq.delete();
            m_rr = 0;
            for (int c = 0; c < NUM_CH; c++) m_key[c] = 16'hFFFF;
        end else begin
            if (pop) void'(mq.pop_front());
            if (p >= 0) begin
                e.ch  = p;
                e.d   = req_data[p*16 +: 16] ^ m_key[p];
                e.rdy = cyc + 2 + ENG_LAT;
                mq.push_back(e);
                m_rr = (p + 1) % NUM_CH;
            end
            if (cfg_we && cfg_ch < NUM_CH) m_key[cfg_ch] = cfg_key;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_word(input int ch, input logic [15:0] d);
        req_data[ch*16 +: 16] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; cfg_we = 1'b0; resp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = 4'hF;
        #1;
        total++; if (eng_valid !== 1'b0)  begin bad++; $display("FAIL reset_eng_valid got=%h exp=0", eng_valid); end
        total++; if (eng_data !== 16'h0)  begin bad++; $display("FAIL reset_eng_data got=%h exp=0", eng_data); end
        total++; if (eng_key !== 16'h0)   begin bad++; $display("FAIL reset_eng_key got=%h exp=0", eng_key); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%h exp=0", resp_valid); end
        total++; if (resp_ch !== 2'd0)    begin bad++; $display("FAIL reset_resp_ch got=%h exp=0", resp_ch); end
        total++; if (resp_data !== 16'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_rr_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        resp_ready = 1'b0;
        req_valid = 4'b0010; set_word(1, 16'h1234);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        total++; if (eng_valid !== 1'b1)    begin bad++; $display("FAIL single_eng_valid got=%h exp=1", eng_valid); end
        total++; if (eng_data !== 16'h1234) begin bad++; $display("FAIL single_eng_data got=%h exp=1234", eng_data); end
        total++; if (eng_key !== 16'hFFFF)  begin bad++; $display("FAIL single_eng_key got=%h exp=ffff", eng_key); end
        tick();
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_early_resp got=%h exp=0", resp_valid); end
        total++; if (eng_valid !== 1'b0)  begin bad++; $display("FAIL single_eng_idle got=%h exp=0", eng_valid); end
        tick();
        #1;
        total++; if (resp_valid !== 1'b1)    begin bad++; $display("FAIL single_resp_valid got=%h exp=1", resp_valid); end
        total++; if (resp_ch !== 2'd1)       begin bad++; $display("FAIL single_resp_ch got=%h exp=1", resp_ch); end
        total++; if (resp_data !== 16'hEDCB) begin bad++; $display("FAIL single_resp_data got=%h exp=edcb", resp_data); end
        resp_ready = 1'b1;
        tick();
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%h exp=0", resp_valid); end
    endtask

    task automatic test_cfg_key();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_key = 16'h00FF;
        tick();
        cfg_we = 1'b0;
        req_valid = 4'b0100; set_word(2, 16'hAB00);
        tick();
        req_valid = '0;
        tick(); tick();
        #1;
        total++; if (resp_valid !== 1'b1)    begin bad++; $display("FAIL cfg_resp_valid got=%h exp=1", resp_valid); end
        total++; if (resp_ch !== 2'd2)       begin bad++; $display("FAIL cfg_resp_ch got=%h exp=2", resp_ch); end
        total++; if (resp_data !== 16'hABFF) begin bad++; $display("FAIL cfg_resp_data got=%h exp=abff", resp_data); end
        tick();
    endtask

    task automatic test_round_robin();
        int k;
        logic [3:0] exp_rdy;
        do_reset();
        resp_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 12; n++) begin
            req_valid = (n < 6) ? 4'hF : 4'h0;
            for (int c = 0; c < NUM_CH; c++) set_word(c, 16'($urandom));
            #1;
            exp_rdy = (n < 6) ? 4'(1 << (n % 4)) : 4'h0;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, req_ready, exp_rdy); end
            if (resp_valid) begin
                total++; if (resp_ch !== 2'(k % 4)) begin bad++; $display("FAIL rr_resp_ch k=%0d got=%0d exp=%0d", k, resp_ch, k % 4); end
                if (mq.size() > 0) begin
                    total++; if (resp_data !== mq[0].d) begin bad++; $display("FAIL rr_resp_data got=%h exp=%h", resp_data, mq[0].d); end
                end
                k++;
            end
            tick();
        end
        total++; if (k != 6) begin bad++; $display("FAIL rr_resp_count got=%0d exp=6", k); end
    endtask

    task automatic test_credit();
        int hs;
        do_reset();
        resp_ready = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < NUM_CH; c++) set_word(c, 16'($urandom));
        hs = 0;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (req_ready != 0) hs++;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL credit_ready n=%0d got=%b exp=%b", n, req_ready, m_ready()); end
            tick();
        end
        total++; if (hs != RESP_DEPTH) begin bad++; $display("FAIL credit_handshakes got=%0d exp=%0d", hs, RESP_DEPTH); end
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL credit_not_comb got=%b exp=0000", req_ready); end
        total++; if (resp_valid !== 1'b1)   begin bad++; $display("FAIL credit_full_valid got=%h exp=1", resp_valid); end
        tick();
        resp_ready = 1'b0;
        hs = 0;
        for (int n = 0; n < 4; n++) begin
            #1;
            if (n == 0) begin
                total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL credit_regrant got=%b exp=0001", req_ready); end
            end
            if (req_ready != 0) hs++;
            tick();
        end
        total++; if (hs != 1) begin bad++; $display("FAIL credit_one_more got=%0d exp=1", hs); end
        req_valid = '0;
    endtask

    task automatic test_key_race();
        do_reset();
        resp_ready = 1'b1;
        req_valid = 4'b0001; set_word(0, 16'h1111);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_key = 16'h0F0F;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL race_ready got=%b exp=0001", req_ready); end
        tick();
        cfg_we = 1'b0; set_word(0, 16'h2222);
        #1;
        total++; if (eng_key !== 16'hFFFF) begin bad++; $display("FAIL race_old_key got=%h exp=ffff", eng_key); end
        tick();
        req_valid = '0;
        #1;
        total++; if (eng_key !== 16'h0F0F) begin bad++; $display("FAIL race_new_key got=%h exp=0f0f", eng_key); end
        tick();
        #1;
        total++; if (resp_data !== 16'hEEEE) begin bad++; $display("FAIL race_resp0 got=%h exp=eeee", resp_data); end
        tick();
        #1;
        total++; if (resp_data !== 16'h2D2D) begin bad++; $display("FAIL race_resp1 got=%h exp=2d2d", resp_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_key = 16'h1234;
        tick();
        cfg_we = 1'b0; resp_ready = 1'b1;
        req_valid = 4'b1000; set_word(3, 16'h5555);
        tick();
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_resp n=%0d got=%h exp=0", n, resp_valid); end
            total++; if (eng_valid !== 1'b0)  begin bad++; $display("FAIL mid_eng_valid n=%0d got=%h exp=0", n, eng_valid); end
            tick();
        end
        req_valid = 4'b1000; set_word(3, 16'h0000);
        tick();
        req_valid = '0;
        #1;
        total++; if (eng_key !== 16'hFFFF) begin bad++; $display("FAIL mid_key_reset got=%h exp=ffff", eng_key); end
        tick(); tick();
        #1;
        total++; if (resp_ch !== 2'd3 || resp_data !== 16'hFFFF) begin
            bad++; $display("FAIL mid_resp got=%0d/%h exp=3/ffff", resp_ch, resp_data);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            req_valid  = 4'($urandom);
            for (int c = 0; c < NUM_CH; c++) set_word(c, 16'($urandom));
            cfg_we     = ($urandom % 8) == 0;
            cfg_ch     = 2'($urandom);
            cfg_key    = 16'($urandom);
            resp_ready = ($urandom % 10) < 7;
            #1;
            total++; if (req_ready !== m_ready()) begin bad++; $display("FAIL rand_req_ready n=%0d got=%b exp=%b", n, req_ready, m_ready()); end
            total++; if (resp_valid !== m_rv())   begin bad++; $display("FAIL rand_resp_valid n=%0d got=%h exp=%h", n, resp_valid, m_rv()); end
            if (m_rv()) begin
                total++; if (resp_ch !== 2'(mq[0].ch)) begin bad++; $display("FAIL rand_resp_ch n=%0d got=%0d exp=%0d", n, resp_ch, mq[0].ch); end
                total++; if (resp_data !== mq[0].d)    begin bad++; $display("FAIL rand_resp_data n=%0d got=%h exp=%h", n, resp_data, mq[0].d); end
            end
            tick();
        end
        req_valid = '0; cfg_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_cfg_key();
        test_round_robin();
        test_credit();
        test_key_race();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
